// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the instruction RAM and the
// decode/execute consumer.
//
// master: the fetch sequencer. It drives the RAM address and the head
//         instruction, and receives RAM data, consumer ready and redirects.
// slave:  the RAM and consumer side, which drives the opposite directions.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  iram_address;
    logic [INSTR_W-1:0] iram_q;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_addr;

    modport master (
        output iram_address,
        input  iram_q,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_addr
    );

    modport slave (
        input  iram_address,
        output iram_q,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_addr
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. It owns the PC, issues one RAM read per cycle
// while credit allows, hides the RAM's 1-cycle read latency behind a 3-entry
// FIFO, and stops fetching once the halt opcode has been captured.
//
// state  | meaning
// IDLE   | after reset; waiting for start
// RUN    | issuing reads and capturing words
// DRAIN  | halt word captured; delivering the remaining buffered words
// HALTED | halt word accepted; waiting for start
module fetch_sequencer #(
    parameter int               ADDR_W      = 8,
    parameter int               INSTR_W     = 16,
    parameter logic [3:0]       HALT_OPCODE = 4'hF,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    fetch_sequencer_if.master bus,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]  pc;
    // s0: address presented to the RAM this cycle; s1: its data is on iram_q
    logic               s0_valid, s1_valid;
    logic [ADDR_W-1:0]  s0_pc, s1_pc;

    logic [INSTR_W-1:0] fifo_data [3];
    logic [ADDR_W-1:0]  fifo_pc   [3];
    logic [1:0]         rd_ptr, wr_ptr, count;

    logic               pop, do_start, do_redirect, capture, halt_cap;
    logic               halt_accept, issue;
    logic [2:0]         outstanding;
    logic [ADDR_W-1:0]  load_addr;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Control decode shared by the FSM and the datapath.
    // A same-cycle pop frees its slot, so credit counts it to keep 1 word/cycle.
    always_comb begin
        pop         = (count != 2'd0) && bus.instr_ready;
        do_start    = start && (state == IDLE || state == HALTED);
        do_redirect = bus.redirect_valid && (state == RUN || state == DRAIN);
        load_addr   = do_start ? START_ADDR : bus.redirect_addr;
        capture     = (state == RUN) && !do_redirect && s1_valid;
        halt_cap    = capture && (bus.iram_q[INSTR_W-1 -: 4] == HALT_OPCODE);
        halt_accept = (state == DRAIN) && pop && (count == 2'd1);
        outstanding = {1'b0, count} + {2'b00, s0_valid} + {2'b00, s1_valid}
                      - {2'b00, pop};
        issue       = (state == RUN) && !do_redirect && !halt_cap
                      && (outstanding < 3'd3);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic; a redirect overrides both halt capture and halt accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (do_start) state_next = RUN;
            RUN:     if (do_redirect) state_next = RUN;
                     else if (halt_cap) state_next = DRAIN;
            DRAIN:   if (do_redirect) state_next = RUN;
                     else if (halt_accept) state_next = HALTED;
            HALTED:  if (do_start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // State-derived outputs and the registered FIFO head.
    always_comb begin
        busy            = (state == RUN) || (state == DRAIN);
        halted          = (state == HALTED);
        bus.instr_valid = (count != 2'd0);
        bus.instr       = fifo_data[rd_ptr];
        bus.instr_pc    = fifo_pc[rd_ptr];
    end

    // PC, read pipeline tags and FIFO. Start/redirect flush everything and
    // present the new target address on the same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.iram_address <= START_ADDR;
            pc               <= '0;
            s0_valid         <= 1'b0;
            s1_valid         <= 1'b0;
            s0_pc            <= '0;
            s1_pc            <= '0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            for (int i = 0; i < 3; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (do_start || do_redirect) begin
            bus.iram_address <= load_addr;
            pc               <= load_addr + 1'b1;
            s0_valid         <= 1'b1;
            s0_pc            <= load_addr;
            s1_valid         <= 1'b0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
        end else begin
            if (issue) begin
                bus.iram_address <= pc;
                pc               <= pc + 1'b1;
                s0_pc            <= pc;
            end
            s0_valid <= issue;
            // words still in flight behind the halt word are dropped
            s1_valid <= s0_valid && !halt_cap;
            s1_pc    <= s0_pc;
            if (capture) begin
                fifo_data[wr_ptr] <= bus.iram_q;
                fifo_pc[wr_ptr]   <= s1_pc;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + {1'b0, capture} - {1'b0, pop};
        end
    end

endmodule
